// File: rtl/load_mem_ctrl.sv
// Single-outstanding load sequencer: EA calc, word read, lane extract/extend, writeback pulse.
// Build option: LOAD_MISALIGN_TRAP_EN traps misaligned LH/LHU/LW instead of silently aligning them.
module load_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] rs1_data_i,
    input  logic [11:0] imm_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o,
    output logic        busy_o
);

    // state   | meaning
    // S_IDLE  | ready for a new load op
    // S_ISSUE | read request presented, waiting for mem_req_ready
    // S_WAIT  | request accepted, waiting for response or timeout
    // S_DONE  | one-cycle writeback pulse
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_err_q, wb_err_d;

    logic [31:0] ea;
    logic        f3_ok;
    logic        misalign;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign ea = rs1_data_i + {{20{imm_i[11]}}, imm_i};

    always_comb begin
        f3_ok = 1'b0;
        case (funct3_i)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_ok = 1'b1;
            default:                             f3_ok = 1'b0;
        endcase
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (funct3_i)
            F3_LH, F3_LHU: misalign = ea[0];
            F3_LW:         misalign = (ea[1:0] != 2'b00);
            default:       misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Halfword lane comes from EA[1] only, so an odd halfword address reads the aligned half.
    assign byte_sel = mem_rdata_i[{lane_q, 3'b000} +: 8];
    assign half_sel = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        load_data = mem_rdata_i;
        case (funct3_q)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    mem_addr_d = {ea[31:2], 2'b00};
                    lane_d     = ea[1:0];
                    funct3_d   = funct3_i;
                    rd_d       = rd_i;
                    if (!f3_ok || misalign) begin
                        state_d   = S_DONE;
                        wb_rd_d   = rd_i;
                        wb_data_d = 32'd0;
                        wb_err_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d   = S_DONE;
                    wb_rd_d   = rd_q;
                    wb_data_d = load_data;
                    wb_err_d  = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    wb_rd_d   = rd_q;
                    wb_data_d = 32'd0;
                    wb_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_addr_q <= 32'd0;
            lane_q     <= 2'd0;
            funct3_q   <= 3'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 8'd0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign mem_req_valid_o = (state_q == S_ISSUE);
    assign mem_addr_o      = mem_addr_q;
    assign wb_valid_o      = (state_q == S_DONE);
    // wb_err is only meaningful alongside wb_valid, so it reads 0 outside DONE.
    assign wb_err_o        = (state_q == S_DONE) && wb_err_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_load_mem_ctrl.sv
// Directed bench for load_mem_ctrl: vector table of single loads plus stall, timeout and reset sequences.
module tb_load_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] rs1_data = '0;
    logic [11:0] imm = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    load_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .rs1_data_i      (rs1_data),
        .imm_i           (imm),
        .funct3_i        (funct3),
        .rd_i            (rd),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_addr_o      (mem_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rdata_i     (mem_rdata),
        .wb_valid_o      (wb_valid),
        .wb_rd_o         (wb_rd),
        .wb_data_o       (wb_data),
        .wb_err_o        (wb_err),
        .busy_o          (busy)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_nreq;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Offers one load, acts as a memory with configurable grant stall and optional response.
    task automatic run_load(input logic [31:0] a_rs1, input logic [11:0] a_imm, input logic [2:0] a_f3,
                            input logic [4:0] a_rd, input logic [31:0] a_rdata, input int stall,
                            input bit give_rsp, output int lat, output int nreq, output logic [31:0] addr,
                            output logic [31:0] data, output logic err, output logic [4:0] wrd,
                            output bit stable_ok, output bit hold_ok);
        int  stall_left;
        bit  issued;
        lat = 0; nreq = 0; addr = '0; data = '0; err = 1'b0; wrd = '0;
        stable_ok = 1'b1; hold_ok = 1'b0; issued = 1'b0; stall_left = stall;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b1; rs1_data = a_rs1; imm = a_imm; funct3 = a_f3; rd = a_rd;
        mem_rdata = a_rdata; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (wb_valid) begin
                lat = c; data = wb_data; err = wb_err; wrd = wb_rd;
                mem_rsp_valid = 1'b0;
                break;
            end
            if (mem_req_valid) begin
                if (nreq == 0) addr = mem_addr;
                else if (mem_addr !== addr) stable_ok = 1'b0;
                if (req_ready || !busy) stable_ok = 1'b0;
                nreq++;
                issued = 1'b1;
                mem_req_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (issued) begin
                mem_req_ready = 1'b0;
                mem_rsp_valid = give_rsp;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            hold_ok = !wb_valid && (wb_data === data);
        end
    endtask

    int          lat, nreq;
    logic [31:0] addr, data;
    logic        err;
    logic [4:0]  wrd;
    bit          stable_ok, hold_ok;

    initial begin
        vecs[0]  = '{32'h0000_1000, 12'h004, 3'b010, 5'd1,  32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 1, 3};
        vecs[1]  = '{32'h0000_2003, 12'h000, 3'b000, 5'd2,  32'h8011_2233, 32'h0000_2000, 32'hFFFF_FF80, 1'b0, 1, 3};
        vecs[2]  = '{32'h0000_2003, 12'h000, 3'b100, 5'd3,  32'h8011_2233, 32'h0000_2000, 32'h0000_0080, 1'b0, 1, 3};
        vecs[3]  = '{32'h0000_2002, 12'h000, 3'b101, 5'd4,  32'h8011_2233, 32'h0000_2000, 32'h0000_8011, 1'b0, 1, 3};
        vecs[4]  = '{32'h0000_2002, 12'h000, 3'b001, 5'd5,  32'h8011_2233, 32'h0000_2000, 32'hFFFF_8011, 1'b0, 1, 3};
        vecs[5]  = '{32'h0000_2001, 12'h000, 3'b000, 5'd6,  32'h8011_2233, 32'h0000_2000, 32'h0000_0022, 1'b0, 1, 3};
        vecs[6]  = '{32'h0000_0010, 12'hFF0, 3'b010, 5'd7,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1, 3};
        vecs[7]  = '{32'hFFFF_FFFC, 12'h008, 3'b010, 5'd8,  32'hCAFE_F00D, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 1, 3};
        vecs[8]  = '{32'h0000_4000, 12'h000, 3'b011, 5'd9,  32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1};
        vecs[9]  = '{32'h0000_3000, 12'h7FF, 3'b100, 5'd10, 32'h8011_2233, 32'h0000_37FC, 32'h0000_0080, 1'b0, 1, 3};
`ifdef LOAD_MISALIGN_TRAP_EN
        vecs[10] = '{32'h0000_3001, 12'h000, 3'b001, 5'd11, 32'h8011_2233, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1};
        vecs[11] = '{32'h0000_1002, 12'h000, 3'b010, 5'd12, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1};
`else
        vecs[10] = '{32'h0000_3001, 12'h000, 3'b001, 5'd11, 32'h8011_2233, 32'h0000_3000, 32'h0000_2233, 1'b0, 1, 3};
        vecs[11] = '{32'h0000_1002, 12'h000, 3'b010, 5'd12, 32'hA5A5_5A5A, 32'h0000_1000, 32'hA5A5_5A5A, 1'b0, 1, 3};
`endif

        #3 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {27'd0, req_ready, mem_req_valid, wb_valid, wb_err, busy}, 32'b10000);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_rd", {27'd0, wb_rd}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            run_load(vecs[v].rs1, vecs[v].imm, vecs[v].f3, vecs[v].rd, vecs[v].rdata, 0, 1'b1,
                     lat, nreq, addr, data, err, wrd, stable_ok, hold_ok);
            check($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_nreq", v), nreq, vecs[v].exp_nreq);
            check($sformatf("v%0d_data", v), data, vecs[v].exp_data);
            check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
            check($sformatf("v%0d_rd", v), {27'd0, wrd}, {27'd0, vecs[v].rd});
            check($sformatf("v%0d_hold", v), {31'd0, hold_ok}, 32'd1);
            if (vecs[v].exp_nreq > 0)
                check($sformatf("v%0d_addr", v), addr, vecs[v].exp_addr);
        end

        // Grant withheld for 5 cycles: request must be held steady for 6.
        run_load(32'h0000_5008, 12'h000, 3'b010, 5'd13, 32'h0BAD_F00D, 5, 1'b1,
                 lat, nreq, addr, data, err, wrd, stable_ok, hold_ok);
        check("stall_nreq", nreq, 6);
        check("stall_stable", {31'd0, stable_ok}, 32'd1);
        check("stall_addr", addr, 32'h0000_5008);
        check("stall_lat", lat, 8);
        check("stall_data", data, 32'h0BAD_F00D);

        // No response: timeout after 4 WAIT cycles.
        run_load(32'h0000_6000, 12'h010, 3'b010, 5'd14, 32'h7777_7777, 0, 1'b0,
                 lat, nreq, addr, data, err, wrd, stable_ok, hold_ok);
        check("to_lat", lat, 6);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_data", data, 32'd0);
        check("to_rd", {27'd0, wrd}, 32'd14);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("late_rsp_idle%0d", c), {30'd0, wb_valid, busy}, 32'd0);
        end
        mem_rsp_valid = 1'b0;
        run_load(32'h0000_6000, 12'h010, 3'b010, 5'd15, 32'h1357_9BDF, 0, 1'b1,
                 lat, nreq, addr, data, err, wrd, stable_ok, hold_ok);
        check("after_to_lat", lat, 3);
        check("after_to_data", data, 32'h1357_9BDF);
        check("after_to_err", {31'd0, err}, 32'd0);

        // Reset while waiting for the response.
        @(negedge clk);
        req_valid = 1'b1; rs1_data = 32'h0000_0500; imm = 12'h000; funct3 = 3'b010; rd = 5'd16;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("pre_rst_wait", {30'd0, mem_req_valid, busy}, 32'b01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {28'd0, mem_req_valid, wb_valid, wb_err, busy}, 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        check("midrst_data", wb_data, 32'd0);
        check("midrst_rd", {27'd0, wb_rd}, 32'd0);
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_rsp_ignored", {29'd0, wb_valid, busy, req_ready}, 32'b001);
        mem_rsp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
